// File: rtl/search_motion.sv
// Field-sweep drive stage: forward legs alternating with left/right turns, with
// stall detection on the current-sense lines that triggers a back-up and turn.
`timescale 1ns/1ps
module search_motion #(
    parameter int unsigned PWM_PERIOD   = 100,
    parameter int unsigned DUTY_FWD     = 70,
    parameter int unsigned DUTY_TURN    = 50,
    parameter int unsigned FWD_TICKS    = 50000,
    parameter int unsigned TURN_TICKS   = 20000,
    parameter int unsigned BACKUP_TICKS = 15000,
    parameter int unsigned STALL_TICKS  = 1000,
    parameter int unsigned DEAD_TICKS   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_searching,
    input  logic       sense_a,
    input  logic       sense_b,
    output logic       pwm_a,
    output logic       pwm_b,
    output logic       dir_a,
    output logic       dir_b,
    output logic [2:0] state_o,
    output logic       stall_pulse,
    output logic [7:0] leg_count
);

    localparam int unsigned MAX_FT    = (FWD_TICKS > TURN_TICKS) ? FWD_TICKS : TURN_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_FT > BACKUP_TICKS) ? MAX_FT : BACKUP_TICKS;
    localparam int unsigned TW        = $clog2(MAX_TICKS + 1);
    localparam int unsigned PW        = $clog2(PWM_PERIOD);
    localparam int unsigned SW        = $clog2(STALL_TICKS + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFwd    = 3'd1,
        StTurnL  = 3'd2,
        StTurnR  = 3'd3,
        StBackup = 3'd4
    } state_e;

    state_e          r_state;
    logic [TW-1:0]   r_timer;
    logic [PW-1:0]   r_pwm_cnt;
    logic [SW-1:0]   r_stall_cnt;
    logic            r_turn_sel;
    logic [7:0]      r_leg_count;
    logic            r_pwm;
    logic            r_dir_a;
    logic            r_dir_b;
    logic            r_stall_pulse;

    state_e          w_state_d;
    logic [TW-1:0]   w_timer_d;
    logic [PW-1:0]   w_pwm_cnt_d;
    logic [SW-1:0]   w_stall_cnt_d;
    logic            w_sense;
    logic            w_active;
    logic            w_stall;
    logic            w_leg_inc;
    logic            w_turn_tgl;
    logic            w_turn_state_d;
    logic [31:0]     w_duty_d;
    logic            w_pwm_d;
    state_e          w_turn_target;

    always_comb begin
        w_state_d     = r_state;
        w_timer_d     = r_timer + 1'b1;
        w_pwm_cnt_d   = (r_pwm_cnt == PW'(PWM_PERIOD - 1)) ? '0 : r_pwm_cnt + 1'b1;
        w_stall_cnt_d = '0;
        w_sense       = sense_a | sense_b;
        w_active      = (r_state == StFwd) || (r_state == StTurnL) || (r_state == StTurnR);
        w_stall       = 1'b0;
        w_leg_inc     = 1'b0;
        w_turn_tgl    = 1'b0;
        w_turn_target = r_turn_sel ? StTurnR : StTurnL;

        if (w_active && w_sense) begin
            if (r_stall_cnt == SW'(STALL_TICKS - 1)) begin
                w_stall = 1'b1;
            end else begin
                w_stall_cnt_d = r_stall_cnt + 1'b1;
            end
        end

        case (r_state)
            StIdle: w_state_d = StFwd;
            StFwd: begin
                if (w_stall) begin
                    w_state_d = StBackup;
                end else if (r_timer == TW'(FWD_TICKS - 1)) begin
                    w_state_d = w_turn_target;
                    w_leg_inc = 1'b1;
                end
            end
            StTurnL, StTurnR: begin
                if (w_stall) begin
                    w_state_d = StBackup;
                end else if (r_timer == TW'(TURN_TICKS - 1)) begin
                    w_state_d  = StFwd;
                    w_turn_tgl = 1'b1;
                end
            end
            StBackup: begin
                if (r_timer == TW'(BACKUP_TICKS - 1)) begin
                    w_state_d = w_turn_target;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Disable overrides every other transition, including a same-cycle stall.
        if (!enable_searching) begin
            w_state_d  = StIdle;
            w_stall    = 1'b0;
            w_leg_inc  = 1'b0;
            w_turn_tgl = 1'b0;
        end

        if ((w_state_d != r_state) || (w_state_d == StIdle)) begin
            w_timer_d     = '0;
            w_pwm_cnt_d   = '0;
            w_stall_cnt_d = '0;
        end

        w_turn_state_d = (w_state_d == StTurnL) || (w_state_d == StTurnR);
        w_duty_d       = w_turn_state_d ? DUTY_TURN : DUTY_FWD;
        w_pwm_d        = (w_state_d != StIdle) && (32'(w_timer_d) >= DEAD_TICKS)
                         && (32'(w_pwm_cnt_d) < w_duty_d);
    end

    // Outputs are registered from next-state values so they align with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_timer       <= '0;
            r_pwm_cnt     <= '0;
            r_stall_cnt   <= '0;
            r_turn_sel    <= 1'b0;
            r_leg_count   <= 8'd0;
            r_pwm         <= 1'b0;
            r_dir_a       <= 1'b0;
            r_dir_b       <= 1'b0;
            r_stall_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_timer       <= w_timer_d;
            r_pwm_cnt     <= w_pwm_cnt_d;
            r_stall_cnt   <= w_stall_cnt_d;
            r_turn_sel    <= r_turn_sel ^ w_turn_tgl;
            r_leg_count   <= r_leg_count + {7'd0, w_leg_inc};
            r_pwm         <= w_pwm_d;
            r_dir_a       <= (w_state_d == StFwd) || (w_state_d == StTurnR);
            r_dir_b       <= (w_state_d == StFwd) || (w_state_d == StTurnL);
            r_stall_pulse <= w_stall;
        end
    end

    assign pwm_a       = r_pwm;
    assign pwm_b       = r_pwm;
    assign dir_a       = r_dir_a;
    assign dir_b       = r_dir_b;
    assign state_o     = r_state;
    assign stall_pulse = r_stall_pulse;
    assign leg_count   = r_leg_count;

endmodule

// File: tb/tb_search_motion.sv
// Directed-vector bench for search_motion using the reduced test-plan parameters.
`timescale 1ns/1ps
module tb_search_motion;

    logic       clk;
    logic       rst_n;
    logic       enable_searching;
    logic       sense_a;
    logic       sense_b;
    logic       pwm_a;
    logic       pwm_b;
    logic       dir_a;
    logic       dir_b;
    logic [2:0] state_o;
    logic       stall_pulse;
    logic [7:0] leg_count;

    int n_tests;
    int n_fail;

    search_motion #(
        .PWM_PERIOD  (10),
        .DUTY_FWD    (7),
        .DUTY_TURN   (5),
        .FWD_TICKS   (40),
        .TURN_TICKS  (20),
        .BACKUP_TICKS(15),
        .STALL_TICKS (8),
        .DEAD_TICKS  (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_searching(enable_searching),
        .sense_a         (sense_a),
        .sense_b         (sense_b),
        .pwm_a           (pwm_a),
        .pwm_b           (pwm_b),
        .dir_a           (dir_a),
        .dir_b           (dir_b),
        .state_o         (state_o),
        .stall_pulse     (stall_pulse),
        .leg_count       (leg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        sa;
        logic        sb;
        int unsigned adv;
        logic [2:0]  st;
        logic        pwm;
        logic        da;
        logic        db;
        logic        stall;
        logic [7:0]  leg;
    } vec_t;

    vec_t vq[$];

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic pwm,
                         input logic da, input logic db, input logic stall,
                         input logic [7:0] leg);
        logic [15:0] act;
        logic [15:0] exp;
        act = {state_o, pwm_a, pwm_b, dir_a, dir_b, stall_pulse, leg_count};
        exp = {st, pwm, pwm, da, db, stall, leg};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d pwm=%b/%b dir=%b/%b stall=%b leg=%0d, want st=%0d pwm=%b dir=%b/%b stall=%b leg=%0d",
                     name, state_o, pwm_a, pwm_b, dir_a, dir_b, stall_pulse, leg_count,
                     st, pwm, da, db, stall, leg);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // {en, sa, sb, adv, state, pwm, dir_a, dir_b, stall, leg}
        // Basic sweep: FWD, TURN_L, FWD, TURN_R
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0,  4, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0,  3, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 29, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1});
        vq.push_back('{1'b1, 1'b0, 1'b0,  2, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1});
        vq.push_back('{1'b1, 1'b0, 1'b0,  3, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1});
        vq.push_back('{1'b1, 1'b0, 1'b0, 14, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1});
        vq.push_back('{1'b1, 1'b0, 1'b0, 40, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2});
        vq.push_back('{1'b1, 1'b0, 1'b0,  4, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2});
        // Stop mid-TURN_R, re-enable; turn_sel was not toggled so TURN_R repeats
        vq.push_back('{1'b0, 1'b0, 1'b0,  1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2});
        vq.push_back('{1'b0, 1'b0, 1'b0,  3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2});
        vq.push_back('{1'b1, 1'b0, 1'b0, 40, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b0, 20, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3});
        // Stall in FWD: 8 sense-high cycles
        vq.push_back('{1'b1, 1'b0, 1'b0,  4, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b1, 1'b0,  7, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b1, 1'b0,  1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b0, 13, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b0, 20, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3});
        // Glitch rejection: 7 high, 1 low, 7 high
        vq.push_back('{1'b1, 1'b0, 1'b1,  7, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b1,  7, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b0, 24, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3});
        vq.push_back('{1'b1, 1'b0, 1'b0,  1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4});
        // Stall on FWD timer 39 beats leg completion
        vq.push_back('{1'b1, 1'b0, 1'b0, 20, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4});
        vq.push_back('{1'b1, 1'b1, 1'b0,  7, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4});
        vq.push_back('{1'b1, 1'b1, 1'b0,  1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4});
        vq.push_back('{1'b1, 1'b0, 1'b0, 15, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4});
        vq.push_back('{1'b1, 1'b0, 1'b0, 20, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4});
        vq.push_back('{1'b1, 1'b0, 1'b0,  5, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4});

        rst_n            = 1'b0;
        enable_searching = 1'b0;
        sense_a          = 1'b0;
        sense_b          = 1'b0;
        #23;
        check("reset_state", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        check("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < vq.size(); i++) begin
            enable_searching = vq[i].en;
            sense_a          = vq[i].sa;
            sense_b          = vq[i].sb;
            tick(vq[i].adv);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].pwm, vq[i].da, vq[i].db,
                  vq[i].stall, vq[i].leg);
        end

        // Asynchronous reset between edges while pwm is high in FWD
        #2;
        rst_n            = 1'b0;
        enable_searching = 1'b0;
        #1;
        check("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        check("post_reset_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // 256 legs: leg_count wraps to 0 on the 256th FWD->turn (a TURN_R)
        enable_searching = 1'b1;
        tick(1);
        check("wrap_start", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(255 * 60);
        check("wrap_leg255", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd255);
        tick(40);
        check("wrap_to_zero", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(20);
        check("wrap_next_fwd", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(40);
        check("wrap_leg1", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
